// File: rtl/i2c_listen_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : i2c_listen_pkg                                         |
// | Brief   : Shared constants for the passive I2C bus listener.     |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package i2c_listen_pkg;

  localparam int I2C_FRAME_BITS = 9;
  localparam int I2C_CNT_WIDTH  = 8;

  // Field positions within a captured frame (8 data bits, then ACK/NAK)
  localparam int DATA_MSB = 8;
  localparam int DATA_LSB = 1;
  localparam int ACK_BIT  = 0;

endpackage
`default_nettype wire

// File: rtl/shift_register.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : shift_register                                          |
// | Brief  : MSB-first serial-in/parallel-out register with clear.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module shift_register
  import i2c_listen_pkg::*;
#(
  parameter int WIDTH = I2C_FRAME_BITS
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             shift_en,
  input  logic             shift_clr,
  output logic [WIDTH-1:0] shift_out
);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_next;

  generate
    if (WIDTH > 1) begin : g_multi
      assign w_next = {r_shift[WIDTH-2:0], din};
    end else begin : g_single
      assign w_next = din;
    end
  endgenerate

  // Clear wins over shift; din is discarded when both are strobed
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (shift_clr) begin
      r_shift <= '0;
    end else if (shift_en) begin
      r_shift <= w_next;
    end
  end

  assign shift_out = r_shift;

endmodule
`default_nettype wire

// File: rtl/up_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : up_counter                                              |
// | Brief  : Clearable wrapping up-counter.                          |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module up_counter
  import i2c_listen_pkg::*;
#(
  parameter int CNT_WIDTH = I2C_CNT_WIDTH
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 cnt_en,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] r_count;

  // Natural modulo-2^CNT_WIDTH wrap, no saturation
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= '0;
    end else if (cnt_en) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/i2c_sample_datapath.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : i2c_sample_datapath                                     |
// | Brief  : I2C listener bit-collection datapath (shift + count).   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module i2c_sample_datapath
  import i2c_listen_pkg::*;
#(
  parameter int WIDTH     = I2C_FRAME_BITS,
  parameter int CNT_WIDTH = I2C_CNT_WIDTH
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 shift_en,
  input  logic                 shift_clr,
  input  logic                 cnt_en,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     shift_out,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 last_bit
);

  localparam logic [CNT_WIDTH-1:0] C_LAST_CNT = CNT_WIDTH'(WIDTH - 1);

  shift_register #(
    .WIDTH (WIDTH)
  ) u_shift (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .din       (din),
    .shift_en  (shift_en),
    .shift_clr (shift_clr),
    .shift_out (shift_out)
  );

  up_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_count (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .count   (count)
  );

  // Zero-latency so the controller knows the current sample closes the frame
  assign last_bit = (count == C_LAST_CNT);

endmodule
`default_nettype wire

// File: tb/tb_i2c_sample_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_i2c_sample_datapath                                  |
// | Brief  : Randomised + directed bench with an arithmetic model.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_i2c_sample_datapath;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       shift_en = 1'b0;
  logic       shift_clr = 1'b0;
  logic       cnt_en = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [8:0] shift_out;
  logic [7:0] count;
  logic       last_bit;

  int checks = 0;
  int errors = 0;

  // Reference state as plain integers
  int m_shift = 0;
  int m_count = 0;
  bit armed   = 1'b0;

  always #5 sysclk = ~sysclk;

  i2c_sample_datapath #(
    .WIDTH     (9),
    .CNT_WIDTH (8)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .din       (din),
    .shift_en  (shift_en),
    .shift_clr (shift_clr),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .shift_out (shift_out),
    .count     (count),
    .last_bit  (last_bit)
  );

  // Model: register = last 9 bits received; counter = events mod 256
  always @(posedge sysclk) begin
    if (!rst_n) begin
      m_shift <= 0;
      m_count <= 0;
      armed   <= 1'b1;
    end else begin
      if (shift_clr)     m_shift <= 0;
      else if (shift_en) m_shift <= (m_shift * 2 + int'(din)) % 512;
      if (cnt_clr)       m_count <= 0;
      else if (cnt_en)   m_count <= (m_count + 1) % 256;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sysclk) begin
    if (armed) begin
      check("model_shift", int'(shift_out), m_shift);
      check("model_count", int'(count), m_count);
      check("model_last_bit", int'(last_bit), (m_count == 8) ? 1 : 0);
    end
  end

  task automatic drive(input logic r, input logic se, input logic sc,
                       input logic ce, input logic cc, input logic d);
    rst_n = r; shift_en = se; shift_clr = sc;
    cnt_en = ce; cnt_clr = cc; din = d;
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int saved_shift;
    int saved_count;
    logic [8:0] pattern;

    // Reset
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_shift", int'(shift_out), 0);
    check("reset_count", int'(count), 0);
    check("reset_last_bit", int'(last_bit), 0);

    // Frame capture 1,0,1,0,1,0,1,0,1
    pattern = 9'b101010101;
    for (int i = 8; i >= 0; i--) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pattern[i]);
      if (i == 1) check("frame_last_bit_at_8", int'(last_bit), 1);
    end
    check("frame_shift", int'(shift_out), 'h155);
    check("frame_data_byte", int'(shift_out[8:1]), 'hAA);
    check("frame_ack_bit", int'(shift_out[0]), 1);
    check("frame_count", int'(count), 9);
    check("frame_last_bit_after", int'(last_bit), 0);

    // Clear priority over enable
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_prio_shift", int'(shift_out), 0);
    check("clr_prio_count", int'(count), 0);

    // Hold with din toggling
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    saved_shift = m_shift;
    saved_count = m_count;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i[0]);
    check("hold_shift", int'(shift_out), saved_shift);
    check("hold_count", int'(count), saved_count);
    check("hold_shift_lit", int'(shift_out), 'h007);
    check("hold_count_lit", int'(count), 3);

    // Counter wrap
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_count_255", int'(count), 255);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_count_0", int'(count), 0);

    // Reset mid-frame
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("midrst_pre_shift", int'(shift_out), 'h00F);
    check("midrst_pre_count", int'(count), 4);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("midrst_shift", int'(shift_out), 0);
    check("midrst_count", int'(count), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("midrst_resume_shift", int'(shift_out), 1);
    check("midrst_resume_count", int'(count), 1);

    // Overflow shift: 10 ones
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ovf_shift", int'(shift_out), 'h1FF);
    check("ovf_count", int'(count), 10);
    check("ovf_last_bit", int'(last_bit), 0);

    // Randomised strobes; clears and reset kept rare so frames build up
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)));
    end

    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_sample_datapath.md
# i2c_sample_datapath

Bit-collection datapath for the passive I2C bus listener. It pairs a serial-in/parallel-out shift register with a clearable up-counter. The listener's control FSM drives shift and count strobes on each SCL rising edge and reads back the assembled frame and bit count. The block makes no decisions about bus protocol; sequencing is done entirely by the strobes.

## Interface
Parameters:
- `WIDTH`, 9: shift register length; one I2C frame is 8 data bits plus the ACK/NAK bit.
- `CNT_WIDTH`, 8: counter width in bits.

Ports:
- `sysclk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `din`  in  1  serial data (SDA level), sampled when `shift_en`=1.
- `shift_en`  in  1  shift `din` into the register this cycle.
- `shift_clr`  in  1  synchronous clear of the shift register.
- `cnt_en`  in  1  increment the counter this cycle.
- `cnt_clr`  in  1  synchronous clear of the counter.
- `shift_out`  out  WIDTH  parallel register contents.
- `count`  out  CNT_WIDTH  current counter value.
- `last_bit`  out  1  combinational; equals (`count` == WIDTH-1).

## Operation
- Shift register, in priority order:
  - `rst_n`=0: `shift_out` becomes 0.
  - else `shift_clr`=1: `shift_out` becomes 0.
  - else `shift_en`=1: `shift_out` becomes {`shift_out`[WIDTH-2:0], `din`}. This is MSB-first: the first bit received ends up at bit WIDTH-1.
  - else hold.
- Full frame layout after WIDTH shifts: `shift_out`[8:1] is the data byte, `shift_out`[0] is the ACK bit (0=ACK, 1=NAK).
- Counter, in priority order:
  - `rst_n`=0: `count` becomes 0.
  - else `cnt_clr`=1: `count` becomes 0.
  - else `cnt_en`=1: `count` becomes `count`+1, modulo 2^CNT_WIDTH. 2^CNT_WIDTH−1 wraps to 0 with no flag or saturation.
  - else hold.
- Shift and count paths are independent. Any combination of strobes is legal in the same cycle.
- `last_bit` is for the controller. If `last_bit`=1 in the same cycle as `cnt_en`=1, that sample is the WIDTH-th bit of the frame.

## Timing
- Reset values: `shift_out`=0, `count`=0, `last_bit`=0 (for WIDTH>1).
- Latency: one cycle. A strobe asserted in cycle N is visible on `shift_out`/`count` in cycle N+1.
- `last_bit` follows `count` combinationally, with zero latency.
- Clear takes priority over enable in the same cycle. `shift_clr`+`shift_en` gives 0, and `din` is discarded. `cnt_clr`+`cnt_en` gives 0.
- Reset mid-frame: takes effect at the next edge regardless of strobes. Partial frame is lost.
- More than WIDTH shifts: the oldest bits fall off the MSB end. No error indication.
- No handshake. Inputs are sampled every cycle. Strobes are expected to be one-cycle pulses but may be held; when held they act once per cycle.

## Structure
- Shared package `i2c_listen_pkg`, containing:
  - `I2C_FRAME_BITS` = 9
  - `I2C_CNT_WIDTH` = 8
  - frame field positions: `DATA_MSB`=8, `DATA_LSB`=1, `ACK_BIT`=0
- Two natural leaf sub-modules instantiated by the top:
  - `shift_register`, ports (din, shift_out, sysclk, shift_en, shift_clr, rst_n)
  - `up_counter`, ports (cnt_en, cnt_clr, count, sysclk, rst_n)
- Top adds only the `last_bit` compare and parameter plumbing.

## Test plan
- Frame capture: after reset, shift in 1,0,1,0,1,0,1,0,1 with `shift_en` and `cnt_en` pulsed together per bit. Required:
  - `shift_out` = 9'h155 (byte 0xAA, ACK bit 1)
  - `count` = 9
  - `last_bit` high exactly while `count` = 8
- Clear priority: with `shift_out`=9'h155 and `count`=9, assert `shift_clr`, `shift_en`, `cnt_clr`, `cnt_en` together with `din`=1. Next cycle `shift_out`=0 and `count`=0.
- Hold: with all strobes low for 20 cycles while `din` toggles, `shift_out` and `count` stay unchanged.
- Counter wrap: issue 255 increments to reach `count`=255, then one more `cnt_en`. Required: `count`=0.
- Reset mid-frame: after 4 shifts of 1 (`shift_out`=9'h00F, `count`=4), drive `rst_n`=0 for one cycle with strobes high. Next cycle both are 0; shifting resumes normally afterwards.
- Overflow shift: shift in 10 ones. Required: `shift_out`=9'h1FF, `count`=10, `last_bit`=0.
